alu_seq: RTL and testbench

- Command-side initiator for the 8-bit ALU (the ALU is the responder).
- Accepts ALU commands on a valid/ready stream and buffers them in a small FIFO.
- Drives the ALU's operand and opcode inputs, waits out the ALU's two-stage registered latency, and captures the result and flags.
- Returns one tagged response per command on a valid/ready stream, strictly in order.

---
 rtl/alu_seq_pkg.sv | 54 +++++
 rtl/alu_seq_fifo.sv | 54 +++++
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, flag bit
// positions, FSM state encoding and a reference ALU function used by the
// optional self-check (build with ALU_SEQ_CHK_EN to enable it).
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Bit positions inside rsp_flags = {overflow, sign, zero, carry}
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_S = 2;
  localparam int FLG_V = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT_C = 3'd2,
    ST_WAIT_R = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Reference ALU: returns {carry, result}. Carry on SUB/DEC means borrow.
  // 8-bit operations return their result zero-extended to 16 bits.
  function automatic logic [16:0] alu_golden(input logic [3:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
    logic [8:0]  wide;
    logic [16:0] ret;
    ret  = '0;
    wide = '0;
    case (op)
      OP_ADD: begin wide = {1'b0, a} + {1'b0, b}; ret = {wide[8], 8'h00, wide[7:0]}; end
      OP_SUB: begin wide = {1'b0, a} - {1'b0, b}; ret = {wide[8], 8'h00, wide[7:0]}; end
      OP_AND: ret = {1'b0, 8'h00, a & b};
      OP_OR:  ret = {1'b0, 8'h00, a | b};
      OP_XOR: ret = {1'b0, 8'h00, a ^ b};
      OP_NOT: ret = {1'b0, 8'h00, ~a};
      OP_INC: begin wide = {1'b0, a} + 9'd1; ret = {wide[8], 8'h00, wide[7:0]}; end
      OP_DEC: begin wide = {1'b0, a} - 9'd1; ret = {wide[8], 8'h00, wide[7:0]}; end
      OP_MUL: ret = {1'b0, 16'(a) * 16'(b)};
      default: ret = '0;
    endcase
    return ret;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO with registered occupancy count. DEPTH must be a power
// of two so the pointers wrap naturally.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and count; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Command-side initiator for the 8-bit two-stage ALU. Commands are queued,
// issued one at a time, the ALU latency is waited out, and one tagged
// response is returned per command in order.
// Optional build macro: ALU_SEQ_CHK_EN adds a reference-model check and the
// sticky chk_err output.
//
// Handshake: both streams transfer on a rising clk edge where valid and
// ready are both 1. A producer holding valid keeps its payload stable until
// that edge; valid never depends combinationally on ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [15:0]      alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             alu_ovf,
  output logic             busy,
`ifdef ALU_SEQ_CHK_EN
  output logic             chk_err,
`endif
  output state_e           state_dbg
);

  localparam int FW = 4 + 8 + 8 + TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e          state;
  logic            live_q;
  logic            fifo_push;
  logic            fifo_pop;
  logic [FW-1:0]   fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign cmd_ready = live_q && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  // No bypass: a freshly pushed command is only visible to IDLE next cycle
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (fifo_count != '0) || (state != ST_IDLE);
  assign state_dbg = state;

  alu_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Hold cmd_ready low while in reset and raise it on the first edge after
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live_q <= 1'b0;
    else      live_q <= 1'b1;
  end

  // Sequencer FSM: issue operands, wait out the ALU stages, capture, respond
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {alu_sel, alu_a, alu_b, rsp_tag} <= fifo_dout;
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: state <= ST_WAIT_C;
        ST_WAIT_C: begin
          // Carry/overflow are only valid for the cycle after sampling
          rsp_flags[FLG_C] <= alu_carry;
          rsp_flags[FLG_V] <= alu_ovf;
          state            <= ST_WAIT_R;
        end
        ST_WAIT_R: begin
          rsp_result       <= alu_out;
          rsp_flags[FLG_Z] <= alu_zero;
          rsp_flags[FLG_S] <= alu_sign;
          rsp_valid        <= 1'b1;
          state            <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_CHK_EN
  logic [16:0] gold;
  logic        gold_sign;
  logic        carry_op;
  logic        mismatch;

  // Compare live ALU outputs with the reference while they are captured
  always_comb begin
    gold      = alu_golden(alu_sel, alu_a, alu_b);
    gold_sign = (alu_sel == OP_MUL) ? gold[15] : gold[7];
    carry_op  = (alu_sel == OP_ADD) || (alu_sel == OP_SUB) ||
                (alu_sel == OP_INC) || (alu_sel == OP_DEC);
    mismatch  = (alu_sel <= OP_MUL) &&
                ((alu_out != gold[15:0]) ||
                 (alu_zero != (gold[15:0] == 16'd0)) ||
                 (alu_sign != gold_sign) ||
                 (carry_op && (rsp_flags[FLG_C] != gold[16])));
  end

  // Sticky error flag, set on the WAIT_R to RESP edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                chk_err <= 1'b0;
    else if (state == ST_WAIT_R && mismatch) chk_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq with a behavioural two-stage ALU responder and an
// in-order response scoreboard. Build with ALU_SEQ_CHK_EN to include the
// checker test.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out = '0;
  logic        alu_carry = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_sign = 1'b0;
  logic        alu_ovf = 1'b0;
  logic        busy;
  state_e      state_dbg;
`ifdef ALU_SEQ_CHK_EN
  logic        chk_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];
  logic        corrupt = 1'b0;

  alu_seq #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .alu_ovf(alu_ovf),
    .busy(busy),
`ifdef ALU_SEQ_CHK_EN
    .chk_err(chk_err),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU (responder) ----------------
  logic [15:0] s1_res = '0;
  logic        s1_sign = 1'b0;

  function automatic logic [17:0] alu_fn(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic c, v;
    logic [15:0] r;
    c = 1'b0; v = 1'b0; r = '0; w = '0;
    case (s)
      4'd0: begin w = a + b; c = w[8]; r = {8'h0, w[7:0]}; v = (a[7] == b[7]) && (w[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; c = w[8]; r = {8'h0, w[7:0]}; v = (a[7] != b[7]) && (w[7] != a[7]); end
      4'd2: r = {8'h0, a & b};
      4'd3: r = {8'h0, a | b};
      4'd4: r = {8'h0, a ^ b};
      4'd5: r = {8'h0, ~a};
      4'd6: begin r = {8'h0, a + 8'd1}; c = (a == 8'hFF); v = (a == 8'h7F); end
      4'd7: begin r = {8'h0, a - 8'd1}; c = (a == 8'h00); v = (a == 8'h80); end
      4'd8: r = a * b;
      default: r = '0;
    endcase
    return {v, c, r};
  endfunction

  always @(posedge clk) begin
    logic [17:0] f;
    f = alu_fn(alu_sel, alu_a, alu_b);
    alu_carry <= f[16];
    alu_ovf   <= f[17];
    s1_res    <= f[15:0];
    s1_sign   <= (alu_sel == 4'd8) ? f[15] : f[7];
    alu_out   <= s1_res ^ {15'd0, corrupt};
    alu_zero  <= (s1_res == 16'd0);
    alu_sign  <= s1_sign;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Issue one command; expected response {tag, flags, result} is queued
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag, input logic [15:0] res, input logic [3:0] fl);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready stayed 0 for tag %h", tag);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back({tag, fl, res});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s: drain timeout, pending=%0d busy=%b", name, exp_q.size(), busy);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got tag=%h flags=%b result=%h, required none",
                 rsp_tag, rsp_flags, rsp_result);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_tag, rsp_flags, rsp_result} !== e) begin
          errors++;
          $display("FAIL rsp: got tag=%h flags=%b result=%h, required tag=%h flags=%b result=%h",
                   rsp_tag, rsp_flags, rsp_result, e[23:20], e[19:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, acc, stale;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {rsp_valid, cmd_ready, busy, rsp_result, rsp_flags, rsp_tag}, 32'd0);
    check("reset_alu", {alu_a, alu_b, alu_sel}, 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", {cmd_ready, busy}, 32'b10);
    rsp_ready = 1'b1;

    // ADD FF+01: latency from push edge to rsp_valid is 4 cycles
    send(OP_ADD, 8'hFF, 8'h01, 4'd3, 16'h0000, 4'b0011);
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin k = i; break; end
    end
    check("add_latency", 32'(k), 32'd4);
    wait_drain("add");

    // Directed vectors, back to back
    send(OP_MUL, 8'hFF, 8'hFF, 4'd1, 16'hFE01, 4'b0100);
    send(OP_MUL, 8'h10, 8'h10, 4'd2, 16'h0100, 4'b0000);
    send(4'hC,   8'h55, 8'hAA, 4'd4, 16'h0000, 4'b0010);
    send(OP_INC, 8'hFF, 8'h00, 4'd5, 16'h0000, 4'b0011);
    send(OP_SUB, 8'h05, 8'h03, 4'd6, 16'h0002, 4'b0000);
    send(OP_SUB, 8'h03, 8'h05, 4'd7, 16'h00FE, 4'b0101);
    send(OP_ADD, 8'h7F, 8'h01, 4'd8, 16'h0080, 4'b1100);
    send(OP_AND, 8'hF0, 8'h3C, 4'd9, 16'h0030, 4'b0000);
    send(OP_OR,  8'h0F, 8'hF0, 4'hA, 16'h00FF, 4'b0100);
    send(OP_XOR, 8'hAA, 8'hAA, 4'hB, 16'h0000, 4'b0010);
    send(OP_NOT, 8'h0F, 8'h00, 4'hC, 16'h00F0, 4'b0100);
    send(OP_DEC, 8'h00, 8'h00, 4'hD, 16'h00FF, 4'b0101);
    send(OP_DEC, 8'h80, 8'h00, 4'hE, 16'h007F, 4'b1000);
    wait_drain("directed");
    check("operand_hold", {alu_sel, alu_a, alu_b}, {4'h0, OP_DEC, 8'h80, 8'h00});

    // Backpressure: exactly FIFO_DEPTH+1 accepted
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 8'(i); cmd_b = 8'h01; cmd_tag = 4'(i);
      if (cmd_ready) begin
        exp_q.push_back({4'(i), 4'b0000, 16'(i + 1)});
        acc++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_ready_low", {cmd_ready, rsp_valid, busy}, 32'b011);
    rsp_ready = 1'b1;
    wait_drain("bp_drain");

    // Reset during WAIT_C with two commands queued
    send(OP_ADD, 8'h01, 8'h01, 4'd1, 16'h0002, 4'b0000);
    send(OP_ADD, 8'h02, 8'h02, 4'd2, 16'h0004, 4'b0000);
    send(OP_ADD, 8'h03, 8'h03, 4'd3, 16'h0006, 4'b0000);
    check("rst_mid_state", 32'(state_dbg), 32'(ST_WAIT_C));
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", {rsp_valid, cmd_ready, busy, rsp_result, rsp_flags, rsp_tag}, 32'd0);
    check("rst_mid_alu", {alu_a, alu_b, alu_sel}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) stale++;
    end
    check("no_stale_rsp", 32'(stale), 32'd0);
    send(OP_XOR, 8'h3C, 8'h0F, 4'd9, 16'h0033, 4'b0000);
    wait_drain("post_reset");

`ifdef ALU_SEQ_CHK_EN
    check("chk_clean", 32'(chk_err), 32'd0);
    corrupt = 1'b1;
    send(OP_ADD, 8'h02, 8'h03, 4'd5, 16'h0004, 4'b0000);
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin k = i; break; end
      check("chk_before_resp", 32'(chk_err), 32'd0);
    end
    check("chk_rise", {k[7:0], 7'd0, chk_err}, {8'd4, 8'd1});
    wait_drain("chk_bad");
    corrupt = 1'b0;
    send(OP_ADD, 8'h02, 8'h03, 4'd6, 16'h0005, 4'b0000);
    wait_drain("chk_good");
    check("chk_sticky", 32'(chk_err), 32'd1);
    @(negedge clk); rst = 1'b0; #1;
    check("chk_reset", 32'(chk_err), 32'd0);
    @(negedge clk); rst = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
